// File: rtl/cache_ctrl.sv
// Purpose : controller for an 8-set direct-mapped word cache (write-through, write-allocate).
// Latency : load hit returns data in the request cycle; miss/store stall IDLE + N memory cycles, data in FILL.
// Backpressure: cpu_stall_o holds the CPU; mem_req_o is held with stable addr/data until mem_ack_i.
// Ports   : clk/rst_n (sync active-low); cpu_* CPU data port; WECache_o/setNmb_o/tag_o/WriteDataCache_o
//           drive the array write port, hit_i/ReadDataCache_i come back from it; mem_* handshaked
//           memory port; hit_cnt_o/miss_cnt_o saturating load hit/miss counters.
module cache_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [31:0]      cpu_addr_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic [31:0]      cpu_rdata_o,
  output logic             cpu_stall_o,
  output logic             WECache_o,
  output logic [2:0]       setNmb_o,
  output logic [26:0]      tag_o,
  output logic [31:0]      WriteDataCache_o,
  input  logic             hit_i,
  input  logic [31:0]      ReadDataCache_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  typedef enum logic [2:0] {
    INIT_RD   = 3'd0,
    INIT_FILL = 3'd1,
    IDLE      = 3'd2,
    MEM_READ  = 3'd3,
    MEM_WRITE = 3'd4,
    FILL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [29:0]      lat_addr;
  logic [31:0]      lat_data;
  logic [2:0]       init_idx;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  // Byte offset within the word is irrelevant to a word cache.
  logic unused_byte_off;
  assign unused_byte_off = ^cpu_addr_i[1:0];

  logic cpu_load, idle_hit, idle_miss;
  assign cpu_load  = cpu_req_i & ~cpu_we_i;
  assign idle_hit  = (state == IDLE) & cpu_load & hit_i;
  assign idle_miss = (state == IDLE) & cpu_load & ~hit_i;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT_RD;
      init_idx <= 3'd0;
      lat_addr <= 30'd0;
      lat_data <= 32'd0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        INIT_RD: if (mem_ack_i) lat_data <= mem_rdata_i;
        // Wraps to 0 after set 7; harmless since init is never re-entered without reset.
        INIT_FILL: init_idx <= init_idx + 3'd1;
        IDLE: begin
          // Latch on every request so MEM_*/FILL see the request that caused the stall;
          // for stores lat_data doubles as the memory write data and the fill data.
          if (cpu_req_i) begin
            lat_addr <= cpu_addr_i[31:2];
            lat_data <= cpu_wdata_i;
          end
          if (idle_hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_ONE;
          if (idle_miss && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_ONE;
        end
        MEM_READ: if (mem_ack_i) lat_data <= mem_rdata_i;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT_RD:   if (mem_ack_i) state_nxt = INIT_FILL;
      INIT_FILL: state_nxt = (init_idx == 3'd7) ? IDLE : INIT_RD;
      IDLE: begin
        if (cpu_req_i) begin
          if (cpu_we_i)    state_nxt = MEM_WRITE;
          else if (!hit_i) state_nxt = MEM_READ;
        end
      end
      MEM_READ:  if (mem_ack_i) state_nxt = FILL;
      MEM_WRITE: if (mem_ack_i) state_nxt = FILL;
      FILL:      state_nxt = IDLE;
      default:   state_nxt = INIT_RD;
    endcase
  end

  // Output logic
  always_comb begin
    cpu_rdata_o      = 32'd0;
    cpu_stall_o      = 1'b1;
    WECache_o        = 1'b0;
    setNmb_o         = lat_addr[2:0];
    tag_o            = lat_addr[29:3];
    WriteDataCache_o = lat_data;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = 32'd0;
    mem_wdata_o      = lat_data;
    unique case (state)
      INIT_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {27'd0, init_idx, 2'b00};
      end
      INIT_FILL: begin
        WECache_o = 1'b1;
        setNmb_o  = init_idx;
        tag_o     = 27'd0;
      end
      IDLE: begin
        // Lookup uses the live CPU address so a hit answers in the same cycle.
        setNmb_o    = cpu_addr_i[4:2];
        tag_o       = cpu_addr_i[31:5];
        cpu_stall_o = cpu_req_i & (cpu_we_i | ~hit_i);
        if (idle_hit) cpu_rdata_o = ReadDataCache_i;
      end
      MEM_READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {lat_addr, 2'b00};
      end
      MEM_WRITE: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {lat_addr, 2'b00};
      end
      FILL: begin
        WECache_o   = 1'b1;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = lat_data;
      end
      default: ;
    endcase
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;

endmodule
